z2_cycle_ctrl: RTL and testbench

Parametrised Zorro II slave cycle controller for the card's bus-facing logic. It synchronises the raw 68000 strobes into MEMCLK and arbitrates among NUM_TARGETS decoded targets (RAM, IDE, control reg, autoconfig, flash, ...). It runs the IDLE/START/DATA/END cycle FSM and generates registered DTACK plus OVR enables. Relative to the previous fixed controller it adds:
- a configurable target count and synchroniser depth;
- a latched one-hot target grant;
- abort on early AS release;
- a DTACK watchdog with sticky error capture.

---
 rtl/z2_cycle_ctrl.sv | 164 ++++++++++++++++
 tb/tb_z2_cycle_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z2_cycle_ctrl.sv
// Zorro II slave cycle controller: strobe synchronisers, target grant, IDLE/START/DATA/END
// cycle FSM with registered DTACK, OVR enable and a DTACK watchdog with sticky error capture.
module z2_cycle_ctrl #(
  parameter int NUM_TARGETS    = 5,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMER_W        = 8,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int TGT_IDX_W      = 4
) (
  input  logic                   MEMCLK,
  input  logic                   RESET_n,
  input  logic                   AS_n,
  input  logic                   UDS_n,
  input  logic                   LDS_n,
  input  logic                   RW,
  input  logic [NUM_TARGETS-1:0] tgt_access,
  input  logic [NUM_TARGETS-1:0] tgt_ready,
  input  logic                   err_clr,
  output logic                   AS_n_s,
  output logic                   UDS_n_s,
  output logic                   LDS_n_s,
  output logic                   RW_s,
  output logic [1:0]             z2_state,
  output logic [NUM_TARGETS-1:0] cycle_tgt,
  output logic                   dtack,
  output logic                   dtack_drive,
  output logic                   ovr,
  output logic                   timeout_err,
  output logic [TGT_IDX_W-1:0]   err_tgt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_END   = 2'd3
  } state_t;

  localparam logic               TMO_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMER_W-1:0] TMO_VAL = TIMER_W'(TIMEOUT_CYCLES);

  function automatic logic [NUM_TARGETS-1:0] lowest_set(input logic [NUM_TARGETS-1:0] v);
    return v & (~v + NUM_TARGETS'(1));
  endfunction

  function automatic logic [TGT_IDX_W-1:0] onehot_idx(input logic [NUM_TARGETS-1:0] v);
    logic [TGT_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (v[i]) idx = TGT_IDX_W'(i);
    end
    return idx;
  endfunction

  logic [SYNC_STAGES-1:0] as_sync_q;
  logic [SYNC_STAGES-2:0] uds_sync_q;
  logic [SYNC_STAGES-2:0] lds_sync_q;
  logic [SYNC_STAGES-2:0] rw_sync_q;
  state_t                 state_q;
  logic [NUM_TARGETS-1:0] cycle_tgt_q;
  logic                   dtack_q;
  logic [TIMER_W-1:0]     timer_q;
  logic                   timeout_err_q;
  logic [TGT_IDX_W-1:0]   err_tgt_q;

  logic                   as_fin;
  logic [TIMER_W-1:0]     timer_d;
  logic [NUM_TARGETS-1:0] grant_d;
  logic                   ready_hit;
  logic                   timeout_hit;

  always_comb begin
    as_fin      = as_sync_q[SYNC_STAGES-1];
    timer_d     = (&timer_q) ? timer_q : timer_q + TIMER_W'(1);
    grant_d     = lowest_set(tgt_access);
    ready_hit   = |(tgt_ready & cycle_tgt_q);
    timeout_hit = TMO_EN && (timer_q >= TMO_VAL);
  end

  always_ff @(posedge MEMCLK) begin
    if (!RESET_n) begin
      as_sync_q     <= '1;
      uds_sync_q    <= '1;
      lds_sync_q    <= '1;
      rw_sync_q     <= '1;
      state_q       <= ST_IDLE;
      cycle_tgt_q   <= '0;
      dtack_q       <= 1'b0;
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
      err_tgt_q     <= '0;
    end else begin
      as_sync_q[0]  <= AS_n;
      uds_sync_q[0] <= UDS_n;
      lds_sync_q[0] <= LDS_n;
      rw_sync_q[0]  <= RW;
      for (int i = 1; i < SYNC_STAGES; i++) as_sync_q[i] <= as_sync_q[i-1];
      for (int i = 1; i < SYNC_STAGES - 1; i++) begin
        uds_sync_q[i] <= uds_sync_q[i-1];
        lds_sync_q[i] <= lds_sync_q[i-1];
        rw_sync_q[i]  <= rw_sync_q[i-1];
      end

      // A timeout firing on the same edge overrides this clear below.
      if (err_clr) timeout_err_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          timer_q <= '0;
          dtack_q <= 1'b0;
          if (!as_fin && |tgt_access) begin
            cycle_tgt_q <= grant_d;
            state_q     <= ST_START;
          end
        end
        ST_START: begin
          timer_q <= timer_d;
          if (AS_n_s) begin
            cycle_tgt_q <= '0;
            state_q     <= ST_IDLE;
          end else if (!UDS_n_s || !LDS_n_s) begin
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          timer_q <= timer_d;
          if (AS_n_s) begin
            cycle_tgt_q <= '0;
            state_q     <= ST_IDLE;
          end else if (ready_hit) begin
            dtack_q <= 1'b1;
            state_q <= ST_END;
          end else if (timeout_hit) begin
            dtack_q       <= 1'b1;
            timeout_err_q <= 1'b1;
            err_tgt_q     <= onehot_idx(cycle_tgt_q);
            state_q       <= ST_END;
          end
        end
        ST_END: begin
          if (AS_n_s) begin
            dtack_q     <= 1'b0;
            cycle_tgt_q <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign AS_n_s      = as_sync_q[SYNC_STAGES-2];
  assign UDS_n_s     = uds_sync_q[SYNC_STAGES-2];
  assign LDS_n_s     = lds_sync_q[SYNC_STAGES-2];
  assign RW_s        = rw_sync_q[SYNC_STAGES-2];
  assign z2_state    = state_q;
  assign cycle_tgt   = cycle_tgt_q;
  assign dtack       = dtack_q;
  assign dtack_drive = dtack_q & |cycle_tgt_q;
  assign ovr         = |tgt_access;
  assign timeout_err = timeout_err_q;
  assign err_tgt     = err_tgt_q;

endmodule

// File: tb/tb_z2_cycle_ctrl.sv
// Bench for z2_cycle_ctrl: two instances (watchdog 16 and watchdog off) on shared stimulus,
// checked every cycle against a cycle-level behavioural model plus directed literal checks.
module tb_z2_cycle_ctrl;

  localparam int NT   = 5;
  localparam int SS   = 3;
  localparam int TMAX = 255;

  logic clk;
  logic rst_n, as_n, uds_n, lds_n, rw, eclr;
  logic [NT-1:0] acc, rdy;

  logic [1:0][1:0]    st_o;
  logic [1:0][NT-1:0] tgt_o;
  logic [1:0][3:0]    etgt_o;
  logic [1:0]         dtk_o, drv_o, err_o, ovr_o, ass_o, uds_o, lds_o, rw_o;

  int n_checks = 0;
  int n_err    = 0;

  z2_cycle_ctrl #(.NUM_TARGETS(NT), .SYNC_STAGES(SS), .TIMER_W(8), .TIMEOUT_CYCLES(16), .TGT_IDX_W(4)) u_a (
    .MEMCLK(clk), .RESET_n(rst_n), .AS_n(as_n), .UDS_n(uds_n), .LDS_n(lds_n), .RW(rw),
    .tgt_access(acc), .tgt_ready(rdy), .err_clr(eclr),
    .AS_n_s(ass_o[0]), .UDS_n_s(uds_o[0]), .LDS_n_s(lds_o[0]), .RW_s(rw_o[0]),
    .z2_state(st_o[0]), .cycle_tgt(tgt_o[0]), .dtack(dtk_o[0]), .dtack_drive(drv_o[0]),
    .ovr(ovr_o[0]), .timeout_err(err_o[0]), .err_tgt(etgt_o[0]));

  z2_cycle_ctrl #(.NUM_TARGETS(NT), .SYNC_STAGES(SS), .TIMER_W(8), .TIMEOUT_CYCLES(0), .TGT_IDX_W(4)) u_b (
    .MEMCLK(clk), .RESET_n(rst_n), .AS_n(as_n), .UDS_n(uds_n), .LDS_n(lds_n), .RW(rw),
    .tgt_access(acc), .tgt_ready(rdy), .err_clr(eclr),
    .AS_n_s(ass_o[1]), .UDS_n_s(uds_o[1]), .LDS_n_s(lds_o[1]), .RW_s(rw_o[1]),
    .z2_state(st_o[1]), .cycle_tgt(tgt_o[1]), .dtack(dtk_o[1]), .dtack_drive(drv_o[1]),
    .ovr(ovr_o[1]), .timeout_err(err_o[1]), .err_tgt(etgt_o[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[0] is the most recent sampled input; hist[n] is n+1 edges old.
  bit   as_h [SS], uds_h [SS], lds_h [SS], rw_h [SS];
  int   m_st [2], m_grant [2], m_tcnt [2], m_errtgt [2];
  bit   m_dtack [2], m_err [2];
  int   tmo [2] = '{16, 0};
  bit   model_ok = 1'b0;

  task automatic model_step(input int k);
    int  told, g;
    bit  asfin, ass, uds, lds;
    told  = (m_tcnt[k] > TMAX) ? TMAX : m_tcnt[k];
    asfin = as_h[SS-1];
    ass   = as_h[SS-2];
    uds   = uds_h[SS-2];
    lds   = lds_h[SS-2];
    if (m_st[k] == 0) m_tcnt[k] = 0;
    else if (m_st[k] == 1 || m_st[k] == 2) m_tcnt[k]++;
    if (eclr) m_err[k] = 1'b0;
    case (m_st[k])
      0: begin
        m_dtack[k] = 1'b0;
        if (!asfin && acc != 0) begin
          g = -1;
          for (int i = NT - 1; i >= 0; i--) if (acc[i]) g = i;
          m_grant[k] = g;
          m_st[k]    = 1;
        end
      end
      1: begin
        if (ass) begin m_grant[k] = -1; m_st[k] = 0; end
        else if (!uds || !lds) m_st[k] = 2;
      end
      2: begin
        if (ass) begin m_grant[k] = -1; m_st[k] = 0; end
        else if (rdy[m_grant[k]]) begin m_dtack[k] = 1'b1; m_st[k] = 3; end
        else if (tmo[k] != 0 && told >= tmo[k]) begin
          m_dtack[k] = 1'b1; m_err[k] = 1'b1; m_errtgt[k] = m_grant[k]; m_st[k] = 3;
        end
      end
      default: begin
        if (ass) begin m_dtack[k] = 1'b0; m_grant[k] = -1; m_st[k] = 0; end
      end
    endcase
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SS; i++) begin
        as_h[i] = 1'b1; uds_h[i] = 1'b1; lds_h[i] = 1'b1; rw_h[i] = 1'b1;
      end
      for (int k = 0; k < 2; k++) begin
        m_st[k] = 0; m_grant[k] = -1; m_tcnt[k] = 0; m_errtgt[k] = 0;
        m_dtack[k] = 1'b0; m_err[k] = 1'b0;
      end
      model_ok = 1'b1;
    end else if (model_ok) begin
      for (int k = 0; k < 2; k++) model_step(k);
      for (int i = SS - 1; i > 0; i--) begin
        as_h[i] = as_h[i-1]; uds_h[i] = uds_h[i-1]; lds_h[i] = lds_h[i-1]; rw_h[i] = rw_h[i-1];
      end
      as_h[0] = as_n; uds_h[0] = uds_n; lds_h[0] = lds_n; rw_h[0] = rw;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int k = 0; k < 2; k++) begin
        chk("state", k, 32'(st_o[k]), 32'(m_st[k]));
        chk("cycle_tgt", k, 32'(tgt_o[k]), (m_grant[k] < 0) ? 32'd0 : (32'd1 << m_grant[k]));
        chk("dtack", k, 32'(dtk_o[k]), 32'(m_dtack[k]));
        chk("dtack_drive", k, 32'(drv_o[k]), 32'(m_dtack[k] && m_grant[k] >= 0));
        chk("timeout_err", k, 32'(err_o[k]), 32'(m_err[k]));
        chk("err_tgt", k, 32'(etgt_o[k]), 32'(m_errtgt[k]));
        chk("ovr", k, 32'(ovr_o[k]), 32'(acc != 0));
        chk("syncs", k, {28'd0, ass_o[k], uds_o[k], lds_o[k], rw_o[k]},
            {28'd0, as_h[SS-2], uds_h[SS-2], lds_h[SS-2], rw_h[SS-2]});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int k, input logic [1:0] s, input int bound, input string nm);
    int n;
    n = 0;
    while (st_o[k] != s && n < bound) begin
      tick();
      n++;
    end
    chk(nm, k, 32'(st_o[k]), 32'(s));
  endtask

  task automatic bus_idle();
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; acc = '0; rdy = '0; eclr = 1'b0;
  endtask

  initial begin
    int cnt;
    bit saw_dtack;
    rst_n = 1'b0; as_n = 1'b0; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
    acc = 5'b00001; rdy = '0; eclr = 1'b0;

    // reset held with an active strobe and decode hit
    repeat (4) begin
      tick();
      chk("rst_state", 0, 32'(st_o[0]), 32'd0);
      chk("rst_dtack", 0, 32'(dtk_o[0]), 32'd0);
      chk("rst_tgt", 0, 32'(tgt_o[0]), 32'd0);
      chk("rst_as_s", 0, 32'(ass_o[0]), 32'd1);
    end
    bus_idle();
    rst_n = 1'b1;
    repeat (4) tick();

    // normal read to target 2
    acc = 5'b00100; as_n = 1'b0; uds_n = 1'b0; rw = 1'b1;
    repeat (3) tick();
    chk("rd_idle_t2", 0, 32'(st_o[0]), 32'd0);
    tick();
    chk("rd_start_t3", 0, 32'(st_o[0]), 32'd1);
    chk("rd_grant", 0, 32'(tgt_o[0]), 32'b00100);
    tick();
    chk("rd_data", 0, 32'(st_o[0]), 32'd2);
    repeat (4) tick();
    chk("rd_wait_dtack", 0, 32'(dtk_o[0]), 32'd0);
    rdy = 5'b00100;
    tick();
    chk("rd_dtack", 0, 32'(dtk_o[0]), 32'd1);
    chk("rd_end", 0, 32'(st_o[0]), 32'd3);
    chk("rd_drive", 0, 32'(drv_o[0]), 32'd1);
    bus_idle();
    repeat (2) tick();
    chk("rd_hold_dtack", 0, 32'(dtk_o[0]), 32'd1);
    tick();
    chk("rd_rel_dtack", 0, 32'(dtk_o[0]), 32'd0);
    chk("rd_rel_state", 0, 32'(st_o[0]), 32'd0);
    chk("rd_rel_tgt", 0, 32'(tgt_o[0]), 32'd0);
    repeat (3) tick();

    // priority and grant hold
    acc = 5'b10010; as_n = 1'b0; lds_n = 1'b0; rw = 1'b0;
    repeat (4) tick();
    chk("pri_grant", 0, 32'(tgt_o[0]), 32'b00010);
    acc = 5'b10000; rdy = 5'b10000;
    repeat (6) begin
      tick();
      chk("pri_ignore_rdy", 0, 32'(dtk_o[0]), 32'd0);
    end
    chk("pri_hold", 0, 32'(tgt_o[0]), 32'b00010);
    rdy = 5'b00010;
    tick();
    chk("pri_dtack", 0, 32'(dtk_o[0]), 32'd1);
    bus_idle();
    wait_state(0, 2'd0, 10, "pri_idle");
    repeat (3) tick();

    // abort while in DATA
    acc = 5'b01000; as_n = 1'b0; uds_n = 1'b0;
    wait_state(0, 2'd2, 10, "abt_data");
    repeat (3) tick();
    as_n = 1'b1;
    saw_dtack = 1'b0;
    repeat (5) begin
      tick();
      if (dtk_o[0]) saw_dtack = 1'b1;
    end
    chk("abt_no_dtack", 0, 32'(saw_dtack), 32'd0);
    chk("abt_state", 0, 32'(st_o[0]), 32'd0);
    chk("abt_tgt", 0, 32'(tgt_o[0]), 32'd0);
    chk("abt_err", 0, 32'(err_o[0]), 32'd0);
    bus_idle();
    repeat (3) tick();

    // watchdog on target 3, and the disabled watchdog instance riding along
    acc = 5'b01000; as_n = 1'b0; uds_n = 1'b0;
    wait_state(0, 2'd2, 10, "wd_data");
    cnt = 0;
    while (!dtk_o[0] && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("wd_cycles", 0, 32'(cnt), 32'd16);
    chk("wd_err", 0, 32'(err_o[0]), 32'd1);
    chk("wd_err_tgt", 0, 32'(etgt_o[0]), 32'd3);
    chk("wd_b_state", 1, 32'(st_o[1]), 32'd2);
    repeat (600) tick();
    chk("nowd_state", 1, 32'(st_o[1]), 32'd2);
    chk("nowd_dtack", 1, 32'(dtk_o[1]), 32'd0);
    chk("nowd_err", 1, 32'(err_o[1]), 32'd0);
    eclr = 1'b1;
    tick();
    eclr = 1'b0;
    chk("clr_err", 0, 32'(err_o[0]), 32'd0);
    chk("clr_tgt_hold", 0, 32'(etgt_o[0]), 32'd3);
    bus_idle();
    wait_state(0, 2'd0, 10, "wd_idle");
    wait_state(1, 2'd0, 10, "nowd_idle");
    repeat (3) tick();

    // timeout and clear on the same edge: set wins
    acc = 5'b00001; as_n = 1'b0; lds_n = 1'b0;
    wait_state(0, 2'd2, 10, "race_data");
    repeat (15) tick();
    eclr = 1'b1;
    tick();
    eclr = 1'b0;
    chk("race_dtack", 0, 32'(dtk_o[0]), 32'd1);
    chk("race_err_set", 0, 32'(err_o[0]), 32'd1);
    chk("race_err_tgt", 0, 32'(etgt_o[0]), 32'd0);
    bus_idle();
    wait_state(0, 2'd0, 10, "race_idle");

    // randomized traffic, including mid-cycle resets
    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(0, 19) == 0) as_n = ~as_n;
      if ($urandom_range(0, 4) == 0) uds_n = ~uds_n;
      if ($urandom_range(0, 4) == 0) lds_n = ~lds_n;
      if ($urandom_range(0, 3) == 0) rw = ~rw;
      if ($urandom_range(0, 5) == 0) acc = NT'($urandom_range(0, 31));
      rdy   = ($urandom_range(0, 7) == 0) ? NT'($urandom_range(0, 31)) : '0;
      eclr  = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;
    bus_idle();
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
